prim_ram_arb_ctrl: RTL and testbench

PRIM_RAM_ARB_CTRL -- requirements
Module: prim_ram_arb_ctrl

---
 rtl/prim_ram_arb_ctrl.sv | 152 +++++++++++++++
 tb/tb_prim_ram_arb_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_ram_arb_ctrl.sv
// Round-robin arbiter sharing one single-port RAM among NumReq requesters, with optional zero-fill after reset.
// Latency: grant is combinational in the request cycle; read data and rvalid_o arrive one cycle after the grant.
// Backpressure: a requester holds req_i and its payload until gnt_o; requests made while filling stall until the fill ends.
module prim_ram_arb_ctrl #(
    parameter int Width       = 32,
    parameter int Depth       = 128,
    parameter int NumReq      = 2,
    parameter bit InitOnReset = 1'b1,
    parameter int Aw          = $clog2(Depth)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]        write_i,
    input  logic [NumReq*Aw-1:0]     addr_i,
    input  logic [NumReq*Width-1:0]  wdata_i,
    input  logic [NumReq*Width-1:0]  wmask_i,
    output logic [NumReq-1:0]        gnt_o,
    output logic [NumReq-1:0]        rvalid_o,
    output logic [Width-1:0]         rdata_o,
    output logic                     init_done_o,
    output logic                     ram_req_o,
    output logic                     ram_write_o,
    output logic [Aw-1:0]            ram_addr_o,
    output logic [Width-1:0]         ram_wdata_o,
    output logic [Width-1:0]         ram_wmask_o,
    input  logic [Width-1:0]         ram_rdata_i
);

    localparam int PtrW = $clog2(NumReq);

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Without a fill the controller comes out of reset already serviceable.
    localparam state_e ResetSt = InitOnReset ? StInit : StRun;

    state_e          state_q, state_d;
    logic [Aw-1:0]   fill_q, fill_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            rd_pend_q, rd_pend_d;
    logic [PtrW-1:0] rd_id_q, rd_id_d;

    logic            gnt_vld;
    logic [PtrW-1:0] gnt_idx;

    // Round-robin search starting at ptr_q; descending loop so the nearest requester wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (state_q == StRun) begin
            for (int k = NumReq - 1; k >= 0; k--) begin
                idx = PtrW'((int'(ptr_q) + k) % NumReq);
                if (req_i[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    // FSM next state and fill counter; the write at Depth-1 is the last fill cycle.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            StInit: begin
                fill_d = fill_q + 1'b1;
                if (fill_q == Aw'(Depth - 1)) begin
                    state_d = StRun;
                    fill_d  = '0;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = ResetSt;
                fill_d  = '0;
            end
        endcase
    end

    // RAM port and grant outputs: fill writes while initialising, granted payload while running.
    always_comb begin
        gnt_o       = '0;
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        if (state_q == StInit) begin
            ram_req_o   = 1'b1;
            ram_write_o = 1'b1;
            ram_addr_o  = fill_q;
            ram_wmask_o = '1;
        end else if (gnt_vld) begin
            gnt_o[gnt_idx] = 1'b1;
            ram_req_o      = 1'b1;
            ram_write_o    = write_i[gnt_idx];
            ram_addr_o     = addr_i[gnt_idx*Aw +: Aw];
            ram_wdata_o    = wdata_i[gnt_idx*Width +: Width];
            ram_wmask_o    = wmask_i[gnt_idx*Width +: Width];
        end
    end

    // Pointer moves past the winner only when something was granted; granted reads become pending.
    always_comb begin
        ptr_d     = ptr_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;
        if (gnt_vld) begin
            ptr_d     = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
            rd_pend_d = ~write_i[gnt_idx];
            rd_id_d   = gnt_idx;
        end
    end

    // State registers; reset drops any read in flight so no stale rvalid_o follows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ResetSt;
            fill_q    <= '0;
            ptr_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Read response: RAM data is forwarded only in the cycle its rvalid_o bit is set.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rd_pend_q) begin
            rvalid_o[rd_id_q] = 1'b1;
            rdata_o           = ram_rdata_i;
        end
    end

    assign init_done_o = (state_q == StRun);

endmodule

// File: tb/tb_prim_ram_arb_ctrl.sv
// Bench for prim_ram_arb_ctrl: a 128-word/2-requester instance checked every cycle against a shadow model,
// plus a 100-word/3-requester instance without fill checked by directed steps.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_prim_ram_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: Depth 128, NumReq 2, fill on reset ----------------
    logic        rst_n;
    logic [1:0]  req, wr;
    logic [13:0] addr;
    logic [63:0] wdata, wmask;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        init_done, ram_req, ram_write;
    logic [6:0]  ram_addr;
    logic [31:0] ram_wdata, ram_wmask, ram_rdata;

    prim_ram_arb_ctrl #(.Width(32), .Depth(128), .NumReq(2), .InitOnReset(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .init_done_o(init_done), .ram_req_o(ram_req), .ram_write_o(ram_write),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
        .ram_rdata_i(ram_rdata)
    );

    // RAM attached to instance A, starting with garbage so the fill is visible.
    logic [31:0] mem_a [128];
    initial for (int i = 0; i < 128; i++) mem_a[i] = $urandom;
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_write) mem_a[ram_addr] <= (mem_a[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            else           ram_rdata <= mem_a[ram_addr];
        end
    end

    // ---------------- instance B: Depth 100, NumReq 3, no fill ----------------
    logic [2:0]  req_b, wr_b, gnt_b, rvalid_b;
    logic [20:0] addr_b;
    logic [95:0] wdata_b, wmask_b;
    logic [31:0] rdata_b, ram_wdata_b, ram_wmask_b, ram_rdata_b;
    logic        init_done_b, ram_req_b, ram_write_b;
    logic [6:0]  ram_addr_b;

    prim_ram_arb_ctrl #(.Width(32), .Depth(100), .NumReq(3), .InitOnReset(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .write_i(wr_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .wmask_i(wmask_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .init_done_o(init_done_b), .ram_req_o(ram_req_b), .ram_write_o(ram_write_b),
        .ram_addr_o(ram_addr_b), .ram_wdata_o(ram_wdata_b), .ram_wmask_o(ram_wmask_b),
        .ram_rdata_i(ram_rdata_b)
    );

    logic [31:0] mem_b [100];
    initial for (int i = 0; i < 100; i++) mem_b[i] = 32'hB000_0000 + i;
    always @(posedge clk) begin
        if (ram_req_b) begin
            if (ram_write_b) mem_b[ram_addr_b] <= (mem_b[ram_addr_b] & ~ram_wmask_b) | (ram_wdata_b & ram_wmask_b);
            else             ram_rdata_b <= mem_b[ram_addr_b];
        end
    end

    // ---------------- reference model for instance A ----------------
    logic [31:0] sm [128];   // shadow of RAM contents as the spec says they should be
    bit          in_run;
    int          fill;
    int          p;          // round-robin start
    int          pend;       // requester owed read data this cycle, -1 if none
    logic [31:0] pend_dat;
    int          last_w;     // requester granted in the last step, -1 if none

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of instance A: predict, compare, then advance the model at the rising edge.
    task automatic step();
        int          w;
        int          a;
        logic [1:0]  e_gnt, e_rv;
        logic        e_req, e_wr;
        logic [6:0]  e_addr;
        logic [31:0] e_wd, e_wm, e_rd;
        #1;
        if (!rst_n) begin
            in_run = 0; fill = 0; p = 0; pend = -1;
        end
        w = -1; e_gnt = '0; e_req = 0; e_wr = 0; e_addr = '0; e_wd = '0; e_wm = '0;
        if (!in_run) begin
            e_req = 1; e_wr = 1; e_addr = 7'(fill); e_wm = '1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (w < 0 && req[(p + k) % 2]) w = (p + k) % 2;
            if (w >= 0) begin
                e_gnt[w] = 1'b1; e_req = 1; e_wr = wr[w];
                e_addr = addr[w*7 +: 7]; e_wd = wdata[w*32 +: 32]; e_wm = wmask[w*32 +: 32];
            end
        end
        e_rv = '0; e_rd = '0;
        if (pend >= 0) begin
            e_rv[pend] = 1'b1; e_rd = pend_dat;
        end
        chk($sformatf("init_done t=%0t", $time), init_done, in_run);
        chk($sformatf("gnt t=%0t", $time),       gnt,       e_gnt);
        chk($sformatf("ram_req t=%0t", $time),   ram_req,   e_req);
        chk($sformatf("ram_write t=%0t", $time), ram_write, e_wr);
        chk($sformatf("ram_addr t=%0t", $time),  ram_addr,  e_addr);
        chk($sformatf("ram_wdata t=%0t", $time), ram_wdata, e_wd);
        chk($sformatf("ram_wmask t=%0t", $time), ram_wmask, e_wm);
        chk($sformatf("rvalid t=%0t", $time),    rvalid,    e_rv);
        chk($sformatf("rdata t=%0t", $time),     rdata,     e_rd);
        last_w = w;
        @(posedge clk);
        if (rst_n) begin
            if (!in_run) begin
                sm[fill] = '0;
                fill++;
                if (fill == 128) in_run = 1;
            end else begin
                pend = -1;
                if (w >= 0) begin
                    a = int'(addr[w*7 +: 7]);
                    if (wr[w]) sm[a] = (sm[a] & ~e_wm) | (e_wd & e_wm);
                    else begin
                        pend = w; pend_dat = sm[a];
                    end
                    p = (w + 1) % 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_a(input int i, input bit r, input bit w, input int ad,
                         input logic [31:0] d, input logic [31:0] m);
        req[i] = r; wr[i] = w; addr[i*7 +: 7] = 7'(ad);
        wdata[i*32 +: 32] = d; wmask[i*32 +: 32] = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; req = '0; wr = '0; addr = '0; wdata = '0; wmask = '0;
        req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0; wmask_b = '0;
        in_run = 0; fill = 0; p = 0; pend = -1; pend_dat = '0; last_w = -1;
        @(negedge clk);
        step();                                   // reset state
        step();
        rst_n = 1;

        // Instance B leaves reset straight in RUN.
        #1 chk("b_init_done_after_reset", init_done_b, 1'b1);
        chk("b_no_grant_idle", gnt_b, 3'b000);

        // Fill up to address 60, then pulse reset: fill must restart.
        repeat (60) step();
        rst_n = 0;
        step();
        rst_n = 1;

        // Both requesters read during INIT: stalled, then alternate 01,10,... once running.
        set_a(0, 1, 0, 3,  '0, '0);
        set_a(1, 1, 0, 77, '0, '0);
        repeat (134) step();

        // Req0 writes DEADBEEF to 5, req1 reads 5.
        set_a(0, 1, 1, 5, 32'hDEADBEEF, 32'hFFFF_FFFF);
        set_a(1, 0, 0, 5, '0, '0);
        while (1) begin
            step();
            if (last_w == 0 || !in_run) break;
        end
        set_a(0, 0, 0, 0, '0, '0);
        set_a(1, 1, 0, 5, '0, '0);
        step();
        req = '0;
        #1 chk("rvalid_after_read5", rvalid, 2'b10);
        chk("rdata_deadbeef", rdata, 32'hDEADBEEF);
        step();

        // Partial-mask write then read back.
        set_a(1, 1, 1, 6, 32'h1234_5678, 32'h0000_FFFF);
        step();
        set_a(1, 1, 0, 6, '0, '0);
        step();
        req = '0;
        #1 chk("rdata_masked", rdata, 32'h0000_5678);
        step();

        // Randomised traffic: hold until granted, occasional withdrawal.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && last_w != i) begin
                    if ($urandom_range(15) == 0) req[i] = 0;
                end else begin
                    set_a(i, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(15),
                          $urandom, ($urandom_range(1) != 0) ? 32'hFFFF_FFFF : $urandom);
                end
            end
            step();
        end
        req = '0;
        step();

        // Reset while a read response is due: it must vanish and never reappear.
        set_a(0, 1, 0, 5, '0, '0);
        set_a(1, 0, 0, 0, '0, '0);
        step();
        req = '0;
        #1 chk("rvalid_before_reset", rvalid, 2'b01);
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (131) step();

        // Instance B: read the last word, then a three-way round robin.
        req = '0;
        req_b = 3'b100; wr_b = '0; addr_b[14 +: 7] = 7'd99;
        #1 chk("b_gnt_read99", gnt_b, 3'b100);
        chk("b_addr_read99", ram_addr_b, 7'd99);
        chk("b_ramreq_read99", {ram_req_b, ram_write_b}, 2'b10);
        @(negedge clk);
        req_b = 3'b000;
        #1 chk("b_rvalid_read99", rvalid_b, 3'b100);
        chk("b_rdata_read99", rdata_b, 32'hB000_0063);
        @(negedge clk);
        #1 chk("b_rvalid_clear", rvalid_b, 3'b000);
        chk("b_rdata_zero", rdata_b, 32'h0);

        req_b = 3'b111; addr_b = {7'd10, 7'd20, 7'd30};
        #1 chk("b_rr0", gnt_b, 3'b001);
        @(negedge clk);
        #1 chk("b_rr1", gnt_b, 3'b010);
        chk("b_rr1_rvalid", rvalid_b, 3'b001);
        chk("b_rr1_rdata", rdata_b, 32'hB000_001E);
        @(negedge clk);
        #1 chk("b_rr2", gnt_b, 3'b100);
        chk("b_rr2_rdata", rdata_b, 32'hB000_0014);
        @(negedge clk);
        #1 chk("b_rr3", gnt_b, 3'b001);
        chk("b_rr3_rdata", rdata_b, 32'hB000_000A);
        req_b = '0;
        @(negedge clk);

        // Instance B: requester 1 writes word 99, requester 0 reads it back; write gives no rvalid.
        req_b = 3'b010; wr_b = 3'b010; addr_b = {7'd0, 7'd99, 7'd0};
        wdata_b[32 +: 32] = 32'hCAFE_F00D; wmask_b[32 +: 32] = 32'hFFFF_FFFF;
        #1 chk("b_gnt_write", gnt_b, 3'b010);
        @(negedge clk);
        req_b = 3'b001; wr_b = '0; addr_b = {7'd0, 7'd0, 7'd99};
        #1 chk("b_no_rvalid_write", rvalid_b, 3'b000);
        chk("b_gnt_readback", gnt_b, 3'b001);
        @(negedge clk);
        req_b = '0;
        #1 chk("b_rvalid_readback", rvalid_b, 3'b001);
        chk("b_rdata_readback", rdata_b, 32'hCAFE_F00D);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
